// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer
// Walks one register-file read port through x0..x31 and emits each register
// as one beat on a valid/ready stream. It holds the core stalled while a dump
// is in progress, so the host sees a consistent snapshot.
// Optional feature macro: REGDUMP_CSUM_EN appends a 33rd beat carrying the XOR
// of all 32 register values. In that case the checksum beat, not x31, is marked last.
module regfile_dump_streamer #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic [DATA_W-1:0] dout_data_o,
    output logic [ADDR_W-1:0] dout_idx_o,
    output logic              dout_last_o,
    output logic              dout_csum_o
);

    // The counter is one bit wider than the address, so the final index never aliases to 0.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              last_reg;
`ifdef REGDUMP_CSUM_EN
    logic [DATA_W-1:0] xor_reg;
    logic              csum_reg;
`endif

    // State and register-index counter; an active-low reset aborts any dump in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: LOAD reads one register, and SEND holds it until the sink accepts it.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (dout_ready_i) begin
                    if (cnt_reg < LAST_CNT) begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = LOAD;
                    end else begin
`ifdef REGDUMP_CSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
            CSUM: begin
`ifdef REGDUMP_CSUM_EN
                if (dout_ready_i) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy and stall cover every non-idle state, and the read address parks at 0 when idle.
    always_comb begin
        busy_o       = (state_reg != IDLE);
        stall_o      = (state_reg != IDLE);
        dout_valid_o = (state_reg == SEND) || (state_reg == CSUM);
        raddr_o      = (state_reg == IDLE) ? '0 : cnt_reg[ADDR_W-1:0];
    end

    // Beat payload registers: capture in LOAD, then hold steady under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= '0;
            idx_reg  <= '0;
            last_reg <= 1'b0;
`ifdef REGDUMP_CSUM_EN
            xor_reg  <= '0;
            csum_reg <= 1'b0;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
`ifdef REGDUMP_CSUM_EN
                    if (start_i) begin
                        xor_reg <= '0;
                    end
`endif
                end
                LOAD: begin
                    data_reg <= rdata_i;
                    idx_reg  <= cnt_reg[ADDR_W-1:0];
`ifdef REGDUMP_CSUM_EN
                    last_reg <= 1'b0;
`else
                    last_reg <= (cnt_reg == LAST_CNT);
`endif
                end
                SEND: begin
                    if (dout_ready_i) begin
                        last_reg <= 1'b0;
`ifdef REGDUMP_CSUM_EN
                        xor_reg <= xor_reg ^ data_reg;
                        // After x31 is accepted, load the checksum beat directly, with no LOAD cycle.
                        if (cnt_reg == LAST_CNT) begin
                            data_reg <= xor_reg ^ data_reg;
                            idx_reg  <= '0;
                            last_reg <= 1'b1;
                            csum_reg <= 1'b1;
                        end
`endif
                    end
                end
                CSUM: begin
`ifdef REGDUMP_CSUM_EN
                    if (dout_ready_i) begin
                        last_reg <= 1'b0;
                        csum_reg <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign dout_data_o = data_reg;
    assign dout_idx_o  = idx_reg;
    assign dout_last_o = last_reg;
`ifdef REGDUMP_CSUM_EN
    assign dout_csum_o = csum_reg;
`else
    assign dout_csum_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Directed testbench for regfile_dump_streamer. It models the register file
// (x0 always reads 0) and checks reset, full dumps, back-pressure, ignored
// start requests and a mid-dump reset. The checksum beat is checked when
// REGDUMP_CSUM_EN is defined.
module tb_regfile_dump_streamer;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;
`ifdef REGDUMP_CSUM_EN
    localparam int NBEATS = REG_NUM + 1;
`else
    localparam int NBEATS = REG_NUM;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              busy_o;
    logic              stall_o;
    logic [ADDR_W-1:0] raddr_o;
    logic [DATA_W-1:0] rdata_i;
    logic              dout_valid_o;
    logic              dout_ready_i;
    logic [DATA_W-1:0] dout_data_o;
    logic [ADDR_W-1:0] dout_idx_o;
    logic              dout_last_o;
    logic              dout_csum_o;

    logic [DATA_W-1:0] regs [REG_NUM];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Combinational register-file read port; x0 is hard-wired to zero.
    assign rdata_i = (raddr_o == '0) ? '0 : regs[raddr_o];

    regfile_dump_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .stall_o      (stall_o),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .dout_data_o  (dout_data_o),
        .dout_idx_o   (dout_idx_o),
        .dout_last_o  (dout_last_o),
        .dout_csum_o  (dout_csum_o)
    );

    // Expected payload of beat b. Beat REG_NUM is the XOR of the register model.
    function automatic logic [DATA_W-1:0] exp_data(input int b);
        logic [DATA_W-1:0] x;
        x = '0;
        if (b >= REG_NUM) begin
            for (int r = 1; r < REG_NUM; r++) x = x ^ regs[r];
            return x;
        end
        return (b == 0) ? '0 : regs[b];
    endfunction

    function automatic logic [ADDR_W-1:0] exp_idx(input int b);
        return (b >= REG_NUM) ? '0 : ADDR_W'(b);
    endfunction

    function automatic logic exp_last(input int b);
        return (b == NBEATS - 1);
    endfunction

    function automatic logic exp_csum(input int b);
        return (b >= REG_NUM);
    endfunction

    // Reset held low: outputs must stay zero even with start_i asserted.
    task automatic test_reset();
        rst          = 1'b0;
        start_i      = 1'b1;
        dout_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, stall_o, dout_valid_o, dout_last_o, dout_csum_o, raddr_o, dout_idx_o, dout_data_o} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got busy=%b stall=%b valid=%b last=%b csum=%b raddr=%0d idx=%0d data=%h want all 0",
                         c, busy_o, stall_o, dout_valid_o, dout_last_o, dout_csum_o, raddr_o, dout_idx_o, dout_data_o);
            end
        end
        start_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got busy=%b want 0", busy_o);
        end
        $display("test_reset done");
    endtask

    // Ready held high. Checks the exact cycle timing: first beat at N+2, one beat per 2 cycles.
    task automatic test_full_dump();
        dout_ready_i = 1'b1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if ({busy_o, stall_o, dout_valid_o} !== 3'b110) begin
            failures++;
            $display("FAIL full_load_state got busy=%b stall=%b valid=%b want 1 1 0", busy_o, stall_o, dout_valid_o);
        end
        @(negedge clk);
        for (int b = 0; b < NBEATS; b++) begin
            checks++;
            if ({dout_valid_o, dout_idx_o, dout_last_o, dout_csum_o, dout_data_o} !==
                {1'b1, exp_idx(b), exp_last(b), exp_csum(b), exp_data(b)}) begin
                failures++;
                $display("FAIL full_beat b=%0d got valid=%b idx=%0d last=%b csum=%b data=%h want valid=1 idx=%0d last=%b csum=%b data=%h",
                         b, dout_valid_o, dout_idx_o, dout_last_o, dout_csum_o, dout_data_o,
                         exp_idx(b), exp_last(b), exp_csum(b), exp_data(b));
            end
            $display("beat b=%0d idx=%0d data=%h last=%b csum=%b", b, dout_idx_o, dout_data_o, dout_last_o, dout_csum_o);
            @(negedge clk);
            if (b < REG_NUM - 1) begin
                checks++;
                if ({dout_valid_o, busy_o} !== 2'b01) begin
                    failures++;
                    $display("FAIL full_gap b=%0d got valid=%b busy=%b want 0 1", b, dout_valid_o, busy_o);
                end
                @(negedge clk);
            end
        end
        checks++;
        if ({busy_o, stall_o, dout_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL full_done got busy=%b stall=%b valid=%b want 0 0 0", busy_o, stall_o, dout_valid_o);
        end
        $display("test_full_dump done");
    endtask

    // Ready is dropped for 5 cycles while idx 7 is on the bus.
    task automatic test_backpressure();
        int exp_b;
        int hold;
        exp_b = 0;
        hold  = 0;
        dout_ready_i = 1'b1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 400 && exp_b < NBEATS; cyc++) begin
            if (dout_valid_o === 1'b1) begin
                if (dout_idx_o == 5'd7 && dout_csum_o === 1'b0 && hold < 5) begin
                    dout_ready_i = 1'b0;
                    checks++;
                    if ({dout_idx_o, dout_data_o, dout_last_o} !== {5'd7, 64'h7777, 1'b0}) begin
                        failures++;
                        $display("FAIL bp_hold n=%0d got idx=%0d data=%h last=%b want idx=7 data=7777 last=0",
                                 hold, dout_idx_o, dout_data_o, dout_last_o);
                    end
                    hold++;
                end else begin
                    dout_ready_i = 1'b1;
                    checks++;
                    if ({dout_idx_o, dout_last_o, dout_data_o} !== {exp_idx(exp_b), exp_last(exp_b), exp_data(exp_b)}) begin
                        failures++;
                        $display("FAIL bp_beat b=%0d got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
                                 exp_b, dout_idx_o, dout_last_o, dout_data_o, exp_idx(exp_b), exp_last(exp_b), exp_data(exp_b));
                    end
                    $display("bp beat b=%0d idx=%0d data=%h", exp_b, dout_idx_o, dout_data_o);
                    exp_b++;
                end
            end else begin
                dout_ready_i = 1'b1;
            end
            @(negedge clk);
        end
        dout_ready_i = 1'b1;
        checks++;
        if (exp_b != NBEATS || hold != 5) begin
            failures++;
            $display("FAIL bp_count got beats=%0d holds=%0d want beats=%0d holds=5", exp_b, hold, NBEATS);
        end
        checks++;
        if ({busy_o, dout_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL bp_done got busy=%b valid=%b want 0 0", busy_o, dout_valid_o);
        end
        $display("test_backpressure done");
    endtask

    // start_i pulses at beat 10 and during the final handshake must both be ignored.
    task automatic test_start_ignored();
        int exp_b;
        exp_b = 0;
        dout_ready_i = 1'b1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 400 && exp_b < NBEATS; cyc++) begin
            start_i = 1'b0;
            if (dout_valid_o === 1'b1) begin
                if (exp_b == 10 || exp_b == NBEATS - 1) start_i = 1'b1;
                checks++;
                if ({dout_idx_o, dout_last_o, dout_data_o} !== {exp_idx(exp_b), exp_last(exp_b), exp_data(exp_b)}) begin
                    failures++;
                    $display("FAIL ign_beat b=%0d got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
                             exp_b, dout_idx_o, dout_last_o, dout_data_o, exp_idx(exp_b), exp_last(exp_b), exp_data(exp_b));
                end
                exp_b++;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++;
        if (exp_b != NBEATS) begin
            failures++;
            $display("FAIL ign_count got beats=%0d want %0d", exp_b, NBEATS);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({busy_o, stall_o, dout_valid_o} !== 3'b000) begin
                failures++;
                $display("FAIL ign_idle cycle=%0d got busy=%b stall=%b valid=%b want 0 0 0", c, busy_o, stall_o, dout_valid_o);
            end
            @(negedge clk);
        end
        $display("test_start_ignored done");
    endtask

    // Reset asserted while beat 15 is valid aborts the dump; a later start restarts from idx 0.
    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        dout_ready_i = 1'b1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (!(dout_valid_o === 1'b1 && dout_idx_o == 5'd15) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            failures++;
            $display("FAIL rstmid_reach got timeout want idx 15 valid");
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout_valid_o, busy_o, stall_o, dout_last_o, dout_idx_o, dout_data_o, raddr_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_abort got valid=%b busy=%b stall=%b last=%b idx=%0d data=%h raddr=%0d want all 0",
                     dout_valid_o, busy_o, stall_o, dout_last_o, dout_idx_o, dout_data_o, raddr_o);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, dout_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_no_resume got busy=%b valid=%b want 0 0", busy_o, dout_valid_o);
        end
        $display("test_reset_mid done");
        test_full_dump();
    endtask

`ifdef REGDUMP_CSUM_EN
    // With all registers set to ones (x0 still 0), the XOR of 31 all-ones words is all ones.
    task automatic test_csum();
        int exp_b;
        for (int r = 0; r < REG_NUM; r++) regs[r] = '1;
        exp_b = 0;
        dout_ready_i = 1'b1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 400 && exp_b < NBEATS; cyc++) begin
            if (dout_valid_o === 1'b1) begin
                if (exp_b == 31) begin
                    checks++;
                    if ({dout_idx_o, dout_last_o, dout_csum_o} !== {5'd31, 1'b0, 1'b0}) begin
                        failures++;
                        $display("FAIL csum_x31 got idx=%0d last=%b csum=%b want idx=31 last=0 csum=0",
                                 dout_idx_o, dout_last_o, dout_csum_o);
                    end
                end
                if (exp_b == 32) begin
                    checks++;
                    if ({dout_idx_o, dout_last_o, dout_csum_o, dout_data_o} !== {5'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
                        failures++;
                        $display("FAIL csum_beat got idx=%0d last=%b csum=%b data=%h want idx=0 last=1 csum=1 data=ffffffffffffffff",
                                 dout_idx_o, dout_last_o, dout_csum_o, dout_data_o);
                    end
                    $display("csum beat data=%h", dout_data_o);
                end
                exp_b++;
            end
            @(negedge clk);
        end
        checks++;
        if (exp_b != NBEATS || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL csum_count got beats=%0d busy=%b want beats=%0d busy=0", exp_b, busy_o, NBEATS);
        end
        $display("test_csum done");
    endtask
`endif

    initial begin
        rst          = 1'b0;
        start_i      = 1'b0;
        dout_ready_i = 1'b0;
        for (int r = 0; r < REG_NUM; r++) regs[r] = DATA_W'(r * 32'h1111);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
`ifdef REGDUMP_CSUM_EN
        test_csum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
